loctag_phase_seq: RTL and testbench

// Programmable multi-mode phase sequencer for the tag front end; generalises the fixed 11b/11n trig timers.
// On a trig rising edge, runs the selected mode's table of up to N_PHASES timed phases (us resolution).

---
 rtl/loctag_phase_seq.sv | 129 ++++++++++++
 tb/tb_loctag_phase_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loctag_phase_seq.sv
// loctag_phase_seq: table-driven multi-mode phase sequencer for the tag front end.
// A trig rising edge runs the selected mode's list of timed phases, driving ctrl_1 per phase.
module loctag_phase_seq #(
    parameter int CLK_DIV  = 50,
    parameter int US_W     = 12,
    parameter int N_MODES  = 4,
    parameter int N_PHASES = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        trig,
    input  logic                                        force_fs,
    input  logic [$clog2(N_MODES)-1:0]                  mode,
    input  logic                                        cfg_we,
    input  logic [$clog2(N_MODES)+$clog2(N_PHASES)-1:0] cfg_addr,
    input  logic [US_W+1:0]                             cfg_data,
    output logic                                        ctrl_1,
    output logic                                        busy,
    output logic [$clog2(N_PHASES)-1:0]                 phase_idx,
    output logic                                        done,
    output logic                                        abort,
    output logic                                        led
);
    localparam int MW    = $clog2(N_MODES);
    localparam int PW    = $clog2(N_PHASES);
    localparam int DW    = US_W + 2;
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {IDLE, RUN, FORCE, DONE} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     tbl_q [N_MODES*N_PHASES];
    logic [DW-1:0]     cur_q, cur_d;
    logic [MW-1:0]     mode_q, mode_d;
    logic [PW-1:0]     phase_q, phase_d, phase_nx;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [US_W-1:0]   us_cnt_q, us_cnt_d;
    logic              trig_m_q, trig_s_q, trig_sd_q;
    logic              rise, tick, done_d, abort_d;

    assign rise     = trig_s_q & ~trig_sd_q;
    assign tick     = div_cnt_q == DIV_W'(CLK_DIV - 1);
    assign phase_nx = phase_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        div_cnt_d = '0;
        us_cnt_d  = '0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        if (force_fs) begin
            state_d = FORCE;
        end else begin
            case (state_q)
                IDLE: if (rise && mode != '0) begin
                    state_d = RUN;
                    mode_d  = mode;
                    phase_d = '0;
                    cur_d   = tbl_q[{mode, {PW{1'b0}}}];
                end
                RUN: if (!trig_s_q) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (us_cnt_q == cur_q[US_W-1:0]) begin
                    if (cur_q[DW-1] || phase_q == PW'(N_PHASES - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = phase_nx;
                        cur_d   = tbl_q[{mode_q, phase_nx}];
                    end
                end else begin
                    // us counter saturates so an over-long phase still ends at all-ones
                    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                    us_cnt_d  = (tick && !(&us_cnt_q)) ? us_cnt_q + US_W'(1) : us_cnt_q;
                end
                DONE:    state_d = trig_s_q ? DONE : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            mode_q    <= '0;
            phase_q   <= '0;
            div_cnt_q <= '0;
            us_cnt_q  <= '0;
            trig_m_q  <= 1'b0;
            trig_s_q  <= 1'b0;
            trig_sd_q <= 1'b0;
            ctrl_1    <= 1'b0;
            busy      <= 1'b0;
            phase_idx <= '0;
            done      <= 1'b0;
            abort     <= 1'b0;
            led       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            div_cnt_q <= div_cnt_d;
            us_cnt_q  <= us_cnt_d;
            trig_m_q  <= trig;
            trig_s_q  <= trig_m_q;
            trig_sd_q <= trig_s_q;
            ctrl_1    <= state_d == RUN ? cur_d[DW-2] : state_d == FORCE;
            busy      <= state_d == RUN;
            phase_idx <= state_d == RUN ? phase_d : '0;
            done      <= done_d;
            abort     <= abort_d;
            led       <= state_d == RUN || state_d == FORCE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_MODES*N_PHASES; i++) tbl_q[i] <= '0;
        end else if (cfg_we) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end
endmodule

// File: tb/tb_loctag_phase_seq.sv
// tb_loctag_phase_seq: directed and random checks of loctag_phase_seq against a phase-schedule model.
module tb_loctag_phase_seq;
    localparam int CLK_DIV = 50;
    localparam int M_IDLE = 0, M_RUN = 1, M_FORCE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1, trig = 1'b0, force_fs = 1'b0, cfg_we = 1'b0;
    logic [1:0]  mode = '0;
    logic [3:0]  cfg_addr = '0;
    logic [13:0] cfg_data = '0;
    logic        ctrl_1, busy, done, abort, led;
    logic [1:0]  phase_idx;

    int n_chk = 0, n_fail = 0;

    loctag_phase_seq dut (
        .clk(clk), .reset(reset), .trig(trig), .force_fs(force_fs), .mode(mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .ctrl_1(ctrl_1), .busy(busy), .phase_idx(phase_idx),
        .done(done), .abort(abort), .led(led)
    );

    always #5 clk = ~clk;

    // Model: each phase is a countdown of dur*CLK_DIV cycles after its entry cycle
    int          m_st = M_IDLE, m_mode = 0, m_ph = 0, m_left = 0;
    logic        m_ctrl = 0, m_last = 0, s1 = 0, s2 = 0, sd = 0;
    logic        e_done = 0, e_abort = 0;
    logic [13:0] m_tbl [16];

    task automatic load(input int p);
        logic [13:0] e;
        e = m_tbl[m_mode*4 + p];
        m_ph = p;
        m_left = int'(e[11:0]) * CLK_DIV;
        m_ctrl = e[12];
        m_last = e[13];
    endtask

    task automatic model();
        logic rise;
        rise = s2 & ~sd;
        e_done = 0;
        e_abort = 0;
        if (reset) begin
            m_st = M_IDLE;
            foreach (m_tbl[i]) m_tbl[i] = '0;
            s1 = 0; s2 = 0; sd = 0;
        end else begin
            if (force_fs) m_st = M_FORCE;
            else if (m_st == M_IDLE) begin
                if (rise && mode != 0) begin
                    m_mode = int'(mode);
                    load(0);
                    m_st = M_RUN;
                end
            end else if (m_st == M_RUN) begin
                if (!s2) begin
                    m_st = M_IDLE;
                    e_abort = 1;
                end else if (m_left == 0) begin
                    if (m_last || m_ph == 3) begin
                        m_st = M_DONE;
                        e_done = 1;
                    end else load(m_ph + 1);
                end else m_left--;
            end else if (m_st == M_DONE) begin
                if (!s2) m_st = M_IDLE;
            end else m_st = M_IDLE;
            if (cfg_we) m_tbl[cfg_addr] = cfg_data;
            sd = s2; s2 = s1; s1 = trig;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("ctrl_1", 32'(ctrl_1), 32'(m_st == M_RUN ? m_ctrl : m_st == M_FORCE));
        chk("busy", 32'(busy), 32'(m_st == M_RUN));
        chk("phase_idx", 32'(phase_idx), m_st == M_RUN ? 32'(m_ph) : 32'd0);
        chk("led", 32'(led), 32'(m_st == M_RUN || m_st == M_FORCE));
        chk("done", 32'(done), 32'(e_done));
        chk("abort", 32'(abort), 32'(e_abort));
    endtask

    task automatic wr(input int m, input int p, input logic last, input logic c, input int dur);
        cfg_we = 1;
        cfg_addr = 4'(m*4 + p);
        cfg_data = {last, c, 12'(dur)};
        step();
        cfg_we = 0;
    endtask

    task automatic rstep();
        cfg_we = ($urandom_range(0, 15) == 0);
        cfg_addr = 4'($urandom_range(0, 15));
        cfg_data = {1'($urandom), 1'($urandom), 12'($urandom_range(0, 4))};
        force_fs = ($urandom_range(0, 199) == 0);
        step();
        cfg_we = 0;
        force_fs = 0;
    endtask

    initial begin
        int hi, lo, nd, na, nb, guard;
        foreach (m_tbl[i]) m_tbl[i] = '0;
        repeat (3) step();
        reset = 0;
        step();

        wr(1, 0, 0, 0, 2);
        wr(1, 1, 1, 1, 3);
        mode = 1;
        trig = 1;
        hi = 0; lo = 0; nd = 0;
        repeat (300) begin
            step();
            if (busy && ctrl_1) hi++;
            if (busy && !ctrl_1) lo++;
            if (done) nd++;
        end
        chk("t1_ctrl_low_clks", 32'(lo), 32'd101);
        chk("t1_ctrl_high_clks", 32'(hi), 32'd151);
        chk("t1_done_pulses", 32'(nd), 32'd1);
        chk("t1_ctrl_after", 32'(ctrl_1), 32'd0);
        trig = 0;
        repeat (5) step();

        trig = 1;
        guard = 0;
        while (!(m_st == M_RUN && m_ph == 1) && guard < 500) begin
            step();
            guard++;
        end
        chk("t2_reach_phase1", 32'(guard < 500), 32'd1);
        repeat (50) step();
        trig = 0;
        na = 0; nd = 0;
        repeat (5) begin
            step();
            if (abort) na++;
            if (done) nd++;
        end
        chk("t2_abort_pulses", 32'(na), 32'd1);
        chk("t2_no_done", 32'(nd), 32'd0);
        chk("t2_ctrl_after", 32'(ctrl_1), 32'd0);

        for (int p = 0; p < 4; p++) wr(2, p, 0, 1'(p), 0);
        mode = 2;
        trig = 1;
        nb = 0; nd = 0;
        repeat (12) begin
            step();
            if (busy) begin
                chk("t3_phase_seq", 32'(phase_idx), 32'(nb));
                nb++;
            end
            if (done) nd++;
        end
        chk("t3_busy_clks", 32'(nb), 32'd4);
        chk("t3_done_pulses", 32'(nd), 32'd1);
        trig = 0;
        repeat (4) step();

        mode = 1;
        trig = 1;
        repeat (20) step();
        force_fs = 1;
        step();
        chk("t4_force_ctrl", 32'(ctrl_1), 32'd1);
        chk("t4_force_led", 32'(led), 32'd1);
        repeat (5) step();
        force_fs = 0;
        nb = 0;
        repeat (10) begin
            step();
            if (busy) nb++;
        end
        chk("t4_no_rerun", 32'(nb), 32'd0);
        trig = 0;
        repeat (4) step();

        mode = 0;
        trig = 1;
        nb = 0;
        repeat (10) begin
            step();
            if (busy) nb++;
        end
        chk("t5_mode0_idle", 32'(nb), 32'd0);
        trig = 0;
        repeat (4) step();
        mode = 1;
        trig = 1;
        repeat (5) step();
        wr(1, 1, 1, 1, 1);
        hi = 0;
        repeat (300) begin
            step();
            if (busy && ctrl_1) hi++;
        end
        chk("t5_new_dur_clks", 32'(hi), 32'd51);
        trig = 0;
        repeat (4) step();

        trig = 1;
        repeat (20) step();
        reset = 1;
        step();
        chk("t6_reset_busy", 32'(busy), 32'd0);
        chk("t6_reset_led", 32'(led), 32'd0);
        reset = 0;
        trig = 0;
        repeat (4) step();
        trig = 1;
        nb = 0;
        repeat (12) begin
            step();
            if (busy) nb++;
        end
        chk("t6_cleared_busy_clks", 32'(nb), 32'd4);
        trig = 0;
        repeat (4) step();

        for (int i = 0; i < 30; i++) begin
            mode = 2'($urandom_range(0, 3));
            trig = 1;
            repeat ($urandom_range(0, 400)) rstep();
            trig = 0;
            repeat ($urandom_range(1, 15)) rstep();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
